// File: rtl/user_sobel_engine_if.sv
// CPU register bus for the Sobel engine: single-beat request, combinational grant,
// response (rvalid/rdata) registered one cycle after every granted request.
interface user_sobel_engine_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/user_sobel_engine.sv
// Sliding 3x3 Sobel engine over an image ROM, results queued in a FIFO; USER_SOBEL_THRESH_EN enables binarised output.
// Latency: 9 fetches to prime + 3 per step + 1 CALC per pixel; a full FIFO stalls CALC, ROM waits on rom_valid_i.
module user_sobel_engine #(
  parameter int unsigned IMG_W     = 16,
  parameter int unsigned IMG_H     = 16,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ROM_BASE  = 0,
  parameter int unsigned RES_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  user_sobel_engine_if.slave    obi,
  output logic                  rom_req_o,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [31:0]           rom_data_i,
  input  logic                  rom_valid_i,
  output logic                  irq_o
);
  localparam int unsigned LW = $clog2(RES_DEPTH);
  localparam int unsigned GW = PIX_W + 4;
  localparam logic [PIX_W-1:0] PMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_CALC, S_SHIFT, S_DONE} state_e;

  state_e            state_q;
  logic [7:0]        row_q, col_q;
  logic [15:0]       cnt_q;
  logic [3:0]        idx_q;
  logic [PIX_W-1:0]  win_q [3][3];
  logic              rom_req_q, irq_q, done_q, err_q, udf_q;
  logic [31:0]       ctrl_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q, rd_mux;
  logic [PIX_W-1:0]  fifo_q [RES_DEPTH];
  logic [LW:0]       wptr_q, rptr_q, level;
  logic              fifo_empty, fifo_full, push, pop;
  logic              wr_en, rd_en, start_req, busy;
  logic [1:0]        reg_sel;
  logic [PIX_W-1:0]  thresh_val, res;
  logic [ADDR_W-1:0] fetch_addr;

  assign obi.gnt    = obi.req;
  assign obi.rvalid = rvalid_q;
  assign obi.rdata  = rdata_q;
  assign rom_req_o  = rom_req_q;
  assign rom_addr_o = rom_req_q ? fetch_addr : '0;
  assign irq_o      = irq_q;

  assign reg_sel    = obi.addr[3:2];
  assign wr_en      = obi.req & obi.we;
  assign rd_en      = obi.req & ~obi.we;
  assign start_req  = wr_en && (reg_sel == 2'd0);
  assign busy       = (state_q == S_PRIME) || (state_q == S_CALC) || (state_q == S_SHIFT);

  assign level      = wptr_q - rptr_q;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (LW+1)'(RES_DEPTH));
  assign pop        = rd_en && (reg_sel == 2'd2) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept the push.
  assign push       = (state_q == S_CALC) && (!fifo_full || pop);

  logic unused_bits;
  assign unused_bits = ^{obi.addr[31:4], obi.addr[1:0], rom_data_i[31:PIX_W]};

  // Window pixels widened so the signed kernel sums cannot overflow.
  logic signed [GW-1:0] w [3][3];
  logic signed [GW-1:0] gx, gy, ax, ay;
  logic [GW-1:0]        mag;
  logic [PIX_W-1:0]     mag_sat;

  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = $signed({4'b0000, win_q[i][j]});
    gx = (w[0][2] + (w[1][2] <<< 1) + w[2][2]) - (w[0][0] + (w[1][0] <<< 1) + w[2][0]);
    gy = (w[2][0] + (w[2][1] <<< 1) + w[2][2]) - (w[0][0] + (w[0][1] <<< 1) + w[0][2]);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag = $unsigned(ax) + $unsigned(ay);
    mag_sat = (mag > {4'b0000, PMAX}) ? PMAX : mag[PIX_W-1:0];
`ifdef USER_SOBEL_THRESH_EN
    res = (mag_sat >= thresh_val) ? PMAX : '0;
`else
    res = mag_sat;
`endif
  end

`ifdef USER_SOBEL_THRESH_EN
  logic [PIX_W-1:0] thresh_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) thresh_q <= '0;
    else if (wr_en && (reg_sel == 2'd3)) thresh_q <= obi.wdata[PIX_W-1:0];
  end
  assign thresh_val = thresh_q;
`else
  assign thresh_val = '0;
`endif

  // PRIME walks the 3x3 window row-major; SHIFT only fills the right column (idx = row).
  always_comb begin
    int dr, dc, r, c;
    dr = int'(idx_q);
    dc = 2;
    if (state_q == S_PRIME) begin
      dr = int'(idx_q) / 3;
      dc = int'(idx_q) % 3;
    end
    r = int'(row_q) + dr - 1;
    c = int'(col_q) + dc - 1;
    if (r < 0) r = 0;
    else if (r > int'(IMG_H) - 1) r = int'(IMG_H) - 1;
    if (c < 0) c = 0;
    else if (c > int'(IMG_W) - 1) c = int'(IMG_W) - 1;
    fetch_addr = ADDR_W'(int'(ROM_BASE) + r * int'(IMG_W) + c);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      rom_req_q <= 1'b0;
      irq_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      udf_q     <= 1'b0;
      ctrl_q    <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_q[i][j] <= '0;
    end else begin
      irq_q <= 1'b0;
      if (wr_en && (reg_sel == 2'd1)) begin
        if (obi.wdata[2]) err_q <= 1'b0;
        if (obi.wdata[3]) udf_q <= 1'b0;
      end
      if (rd_en && (reg_sel == 2'd2) && fifo_empty) udf_q <= 1'b1;
      if (start_req && busy) err_q <= 1'b1;

      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start_req) begin
            ctrl_q <= obi.wdata;
            col_q  <= obi.wdata[7:0];
            row_q  <= obi.wdata[15:8];
            cnt_q  <= obi.wdata[31:16];
            idx_q  <= '0;
            done_q <= 1'b0;
            if (obi.wdata[31:16] == 16'd0) begin
              state_q <= S_DONE;
              irq_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_PRIME;
              rom_req_q <= 1'b1;
            end
          end
        end
        S_PRIME: begin
          if (rom_req_q && rom_valid_i) begin
            for (int i = 0; i < 9; i++)
              if (idx_q == 4'(i)) win_q[i/3][i%3] <= rom_data_i[PIX_W-1:0];
            if (idx_q == 4'd8) begin
              rom_req_q <= 1'b0;
              idx_q     <= '0;
              state_q   <= S_CALC;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_SHIFT: begin
          if (rom_req_q && rom_valid_i) begin
            for (int i = 0; i < 3; i++)
              if (idx_q == 4'(i)) win_q[i][2] <= rom_data_i[PIX_W-1:0];
            if (idx_q == 4'd2) begin
              rom_req_q <= 1'b0;
              idx_q     <= '0;
              state_q   <= S_CALC;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_CALC: begin
          if (push) begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_q <= S_DONE;
              irq_q   <= 1'b1;
              done_q  <= 1'b1;
            end else if (col_q == 8'(IMG_W - 1)) begin
              col_q     <= '0;
              row_q     <= (row_q == 8'(IMG_H - 1)) ? 8'd0 : row_q + 8'd1;
              state_q   <= S_PRIME;
              rom_req_q <= 1'b1;
            end else begin
              col_q <= col_q + 8'd1;
              for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
              end
              state_q   <= S_SHIFT;
              rom_req_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      2'd0: rd_mux = ctrl_q;
      2'd1: rd_mux = {16'b0, 8'(level), 4'b0, udf_q, err_q, done_q, busy};
      2'd2: rd_mux = fifo_empty ? 32'b0 : {{(32-PIX_W){1'b0}}, fifo_q[rptr_q[LW-1:0]]};
      default: rd_mux = {{(32-PIX_W){1'b0}}, thresh_val};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q[LW-1:0]] <= res;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= obi.req;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (obi.req) rdata_q <= rd_en ? rd_mux : 32'b0;
    end
  end
endmodule
